// File: rtl/mlp_sample_sequencer.sv
// rtl/mlp_sample_sequencer.sv - feature acquisition and result capture sequencer for a combinational MLP classifier
//
// Steps the analog mux through N_FEAT features. For each feature it pulses the ADC,
// waits for the conversion and stores the code in a packed feature vector. It then
// lets the classifier settle for SETTLE_CYC cycles and latches its class index.
// The result is offered on a valid/ready handshake.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - request one inference (honoured only when idle)
//   busy       - high whenever not idle
//   adc_sel    - analog mux select = current feature index
//   adc_conv   - one-cycle ADC convert pulse
//   adc_done   - ADC conversion complete, adc_data valid same cycle
//   adc_data   - unsigned ADC code
//   mlp_inp    - registered packed feature vector, feature k at [FEAT_W*k +: FEAT_W]
//   mlp_out    - classifier argmax index
//   res_valid  - result available (held until accepted)
//   res_ready  - consumer accepts result
//   res_class  - captured class index
//   err        - ADC timeout occurred during the current result
//
// Build option: define MLP_SEQ_TIMEOUT_EN to add a per-feature ADC timeout of ADC_TO
// cycles. Without it, WAIT waits forever and err is constant 0.

module mlp_sample_sequencer #(
    parameter int N_FEAT     = 21,
    parameter int FEAT_W     = 4,
    parameter int SETTLE_CYC = 2,
    parameter int ADC_TO     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic [4:0]               adc_sel,
    output logic                     adc_conv,
    input  logic                     adc_done,
    input  logic [FEAT_W-1:0]        adc_data,
    output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [1:0]               mlp_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [1:0]               res_class,
    output logic                     err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t                    r_state;
    logic [4:0]                r_idx;
    logic [3:0]                r_settle;
    logic [N_FEAT*FEAT_W-1:0]  r_inp;
    logic [1:0]                r_class;
    logic                      r_busy;
    logic                      r_conv;
    logic                      r_valid;

    logic                      w_last;
    logic                      w_timeout;
    logic                      w_write;
    int                        w_base;

    assign w_last  = (r_idx == 5'(N_FEAT - 1));
    // A timeout is treated exactly like a conversion that returned code 0.
    assign w_write = (r_state == ST_WAIT) && (adc_done || w_timeout);

    always_comb begin
        w_base = int'(r_idx) * FEAT_W;
    end

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(ADC_TO + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // r_to_cnt counts WAIT cycles without adc_done; the ADC_TO-th such cycle times out.
    assign w_timeout = (r_state == ST_WAIT) && !adc_done && (r_to_cnt == TO_W'(ADC_TO - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;

    // Out-of-range parameter values are unsupported; this block marks such a build
    // in the elaborated hierarchy.
    if (ADC_TO < 1 || SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_illegal_params
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_inp    <= '0;
            r_class  <= '0;
            r_busy   <= 1'b0;
            r_conv   <= 1'b0;
            r_valid  <= 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
            r_to_cnt <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_conv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                        r_conv  <= 1'b1;
`ifdef MLP_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                ST_CONV: begin
                    r_state <= ST_WAIT;
`ifdef MLP_SEQ_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (w_write) begin
                        r_inp[w_base +: FEAT_W] <= adc_done ? adc_data : '0;
`ifdef MLP_SEQ_TIMEOUT_EN
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
`endif
                        if (w_last) begin
                            r_state  <= ST_SETTLE;
                            // Down-counter reaches 0 on the final settle cycle.
                            r_settle <= 4'(SETTLE_CYC - 1);
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= ST_CONV;
                            r_conv  <= 1'b1;
                        end
                    end
`ifdef MLP_SEQ_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_class <= mlp_out;
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign adc_sel   = r_idx;
    assign adc_conv  = r_conv;
    assign mlp_inp   = r_inp;
    assign res_valid = r_valid;
    assign res_class = r_class;

endmodule
